// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
//   state_t : control states of the serial subtractor (IDLE, RUN, DONE)
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : arith_pkg

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
//   in_valid/in_ready/a/b          : operand pair, producer -> block
//   out_valid/out_ready/diff/borrow : result, block -> consumer
// master : the environment side (drives operands, accepts results)
// slave  : the subtractor side
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow
    );
endinterface : serial_subtractor_if

// File: rtl/full_subtractor.sv
// One-bit full subtractor: x - y - bin, built from two half subtractors.
//   x, y : operand bits
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic d1;
    logic b1;
    logic b2;

    half_subtractor u_hs0 (.x(x),  .y(y),   .d(d1), .bout(b1));
    half_subtractor u_hs1 (.x(d1), .y(bin), .d(d),  .bout(b2));

    // The two stage borrows can never both be 1, so OR is enough.
    assign bout = b1 | b2;
endmodule : full_subtractor

// File: rtl/half_subtractor.sv
// One-bit half subtractor: x - y.
//   x, y : operand bits
//   d    : difference bit
//   bout : borrow out (1 when y > x)
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bout
);
    assign d    = x ^ y;
    assign bout = ~x & y;
endmodule : half_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = (a - b) mod 2^WIDTH, borrow = (a < b).
// One bit per clock, LSB first, through a single full subtractor and a borrow flop.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : operand/result handshake (slave side)
// Result appears WIDTH clocks after the accepting edge and is held in DONE
// until out_ready; diff/borrow keep their value until the next RUN.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_r;
    logic             bw;
    logic             d_bit;
    logic             bw_nxt;
    logic             in_ready_c;
    logic             out_valid_c;
    logic             last_bit;

    assign last_bit = (cnt == CW'(WIDTH - 1));

    full_subtractor u_fs (
        .x   (a_sr[0]),
        .y   (b_sr[0]),
        .bin (bw),
        .d   (d_bit),
        .bout(bw_nxt)
    );

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (last_bit) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: the shift registers are cleared on reset so that diff reads 0
    // after an aborted operation instead of leftover partial bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            diff_r <= '0;
            bw     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_sr <= bus.a;
                        b_sr <= bus.b;
                        bw   <= 1'b0;
                        cnt  <= '0;
                    end
                end
                ST_RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    // LSB-first results enter at the MSB and walk down.
                    diff_r <= {d_bit, diff_r[WIDTH-1:1]};
                    bw     <= bw_nxt;
                    cnt    <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.diff      = diff_r;
    assign bus.borrow    = bw;
endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: a WIDTH=8 instance for directed,
// random, backpressure, reset and streaming tests, plus a WIDTH=4 instance
// checked exhaustively. Expected values come from plain integer arithmetic.
module tb_serial_subtractor;

    logic clk;
    logic rst_n;
    int   tests;
    int   failed;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(4)) bus4 ();

    serial_subtractor #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_subtractor #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: unsigned subtraction of w-bit values.
    function automatic void ref_sub(input int a, input int b, input int w,
                                    output int d, output int bo);
        d  = (a - b) & ((1 << w) - 1);
        bo = (a < b) ? 1 : 0;
    endfunction

    // All tasks start and end at 1 time unit after a rising edge.
    task automatic send8(input logic [7:0] a, input logic [7:0] b);
        bus8.a        = a;
        bus8.b        = b;
        bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
    endtask

    task automatic wait_done8(output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (bus8.out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic pop8();
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b);
        int lat, ed, eb;
        ref_sub(int'(a), int'(b), 8, ed, eb);
        check("in_ready_idle", 64'(bus8.in_ready), 64'd1);
        send8(a, b);
        wait_done8(lat);
        check("latency", 64'(lat), 64'd8);
        check("diff", 64'(bus8.diff), 64'(ed));
        check("borrow", 64'(bus8.borrow), 64'(eb));
        pop8();
        check("out_valid_after_pop", 64'(bus8.out_valid), 64'd0);
    endtask

    initial begin
        int lat, ed, eb, last_acc, n_res, cyc;
        logic [7:0] hold_d;
        logic       hold_b;
        logic [8:0] expq[$];
        logic [8:0] e;

        tests  = 0;
        failed = 0;
        rst_n  = 1'b0;
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.out_ready = 1'b0;
        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.out_ready = 1'b0;

        // Reset state, observed while reset is held.
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus8.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus8.out_valid), 64'd0);
        check("rst_diff", 64'(bus8.diff), 64'd0);
        check("rst_borrow", 64'(bus8.borrow), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 64'(bus8.in_ready), 64'd1);

        // Directed corner cases.
        run8(8'd5, 8'd3);
        run8(8'd3, 8'd5);
        run8(8'h00, 8'hFF);
        run8(8'hA5, 8'hA5);
        run8(8'hFF, 8'h00);

        // Random operand pairs.
        for (int i = 0; i < 16; i++) run8(8'($urandom), 8'($urandom));

        // Backpressure: hold the result while the operand side is busy.
        ref_sub(8'h9C, 8'h3D, 8, ed, eb);
        send8(8'h9C, 8'h3D);
        wait_done8(lat);
        check("bp_latency", 64'(lat), 64'd8);
        for (int i = 0; i < 5; i++) begin
            bus8.in_valid = (i % 2 == 0);
            bus8.a        = 8'($urandom);
            bus8.b        = 8'($urandom);
            @(posedge clk); #1;
            check("bp_out_valid", 64'(bus8.out_valid), 64'd1);
            check("bp_in_ready", 64'(bus8.in_ready), 64'd0);
            check("bp_diff", 64'(bus8.diff), 64'(ed));
            check("bp_borrow", 64'(bus8.borrow), 64'(eb));
        end
        bus8.in_valid = 1'b0;
        pop8();
        check("bp_back_idle", 64'(bus8.in_ready), 64'd1);
        check("bp_diff_kept", 64'(bus8.diff), 64'(ed));
        check("bp_borrow_kept", 64'(bus8.borrow), 64'(eb));
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_capture", 64'(bus8.in_ready), 64'd1);

        // Reset mid-RUN after 4 bits.
        send8(8'hC3, 8'h5A);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(bus8.out_valid), 64'd0);
        check("abort_in_ready", 64'(bus8.in_ready), 64'd1);
        check("abort_diff", 64'(bus8.diff), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run8(8'd200, 8'd100);

        // Reset while a result waits in DONE.
        send8(8'h10, 8'h20);
        wait_done8(lat);
        check("done_before_rst", 64'(bus8.out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("done_rst_out_valid", 64'(bus8.out_valid), 64'd0);
        check("done_rst_in_ready", 64'(bus8.in_ready), 64'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run8(8'h10, 8'h20);

        // Streaming with in_valid and out_ready held high.
        last_acc = -1;
        n_res    = 0;
        bus8.a = 8'($urandom);
        bus8.b = 8'($urandom);
        bus8.in_valid  = 1'b1;
        bus8.out_ready = 1'b1;
        for (cyc = 0; cyc < 90; cyc++) begin
            if (cyc == 60) bus8.in_valid = 1'b0;
            if (bus8.out_valid) begin
                if (expq.size() == 0) begin
                    check("stream_unexpected", 64'd1, 64'd0);
                end else begin
                    e = expq.pop_front();
                    check("stream_result", 64'({bus8.borrow, bus8.diff}), 64'(e));
                    n_res++;
                end
            end
            if (bus8.in_ready && bus8.in_valid) begin
                ref_sub(int'(bus8.a), int'(bus8.b), 8, ed, eb);
                expq.push_back({eb[0], ed[7:0]});
                if (last_acc >= 0) check("stream_gap", 64'(cyc - last_acc), 64'd10);
                last_acc = cyc;
            end else begin
                bus8.a = 8'($urandom);
                bus8.b = 8'($urandom);
            end
            @(posedge clk); #1;
        end
        bus8.out_ready = 1'b0;
        check("stream_drained", 64'(expq.size()), 64'd0);
        check("stream_count", 64'(n_res), 64'd6);

        // WIDTH=4: every operand pair.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                ref_sub(ai, bi, 4, ed, eb);
                bus4.a        = 4'(ai);
                bus4.b        = 4'(bi);
                bus4.in_valid = 1'b1;
                @(posedge clk); #1;
                bus4.in_valid = 1'b0;
                lat = 0;
                for (int k = 1; k <= 20; k++) begin
                    @(posedge clk); #1;
                    if (bus4.out_valid) begin
                        lat = k;
                        break;
                    end
                end
                if (ai == 0 && bi == 0) check("w4_latency", 64'(lat), 64'd4);
                if (lat == 0) check("w4_timeout", 64'd0, 64'd1);
                check("w4_pair", 64'({bus4.borrow, bus4.diff}), 64'({eb[0], ed[3:0]}));
                bus4.out_ready = 1'b1;
                @(posedge clk); #1;
                bus4.out_ready = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_serial_subtractor
